// File: rtl/tinyriscv_pkg.sv
// Shared load/store types for the tinyriscv core: access size encoding,
// the per-transaction bookkeeping record, and the load data aligner.
package tinyriscv_pkg;

  typedef enum logic [1:0] {
    LSU_SIZE_BYTE = 2'd0,
    LSU_SIZE_HALF = 2'd1,
    LSU_SIZE_WORD = 2'd2
  } lsu_size_e;

  // Everything needed to turn a bus response back into a writeback.
  // The destination register travels next to this record at the width
  // chosen by the LSU instance, so it is not part of the struct.
  typedef struct packed {
    logic      we;
    lsu_size_e size;
    logic      sgn;
    logic [1:0] off;
  } lsu_entry_t;

  localparam int LSU_ENTRY_W = $bits(lsu_entry_t);

  // Move the addressed lane down to bit 0 and zero/sign-extend it.
  function automatic logic [31:0] lsu_extend(input logic [31:0] rdata,
                                             input lsu_entry_t  e);
    logic [31:0] shifted;
    logic [31:0] result;
    shifted = rdata >> {e.off, 3'b000};
    case (e.size)
      LSU_SIZE_BYTE: result = {{24{e.sgn & shifted[7]}}, shifted[7:0]};
      LSU_SIZE_HALF: result = {{16{e.sgn & shifted[15]}}, shifted[15:0]};
      default:       result = shifted;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/exu_lsu_fifo.sv
// In-order queue of outstanding bus transactions. Each slot carries a
// sticky flag that mark_i sets on every occupied slot at once; a push
// always starts its slot with the flag clear.
module exu_lsu_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  input  logic                         mark_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         flag_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] flag_q;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointer and occupancy bookkeeping; push and pop together leave count alone.
  always_comb begin
    rdPtr_d = pop_i  ? nextPtr(rdPtr_q) : rdPtr_q;
    wrPtr_d = push_i ? nextPtr(wrPtr_q) : wrPtr_q;
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, flags and pointers; a newly pushed slot overrides any mark.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      flag_q  <= '0;
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (mark_i) flag_q <= '1;
      if (push_i) begin
        mem_q[wrPtr_q]  <= data_i;
        flag_q[wrPtr_q] <= 1'b0;
      end
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  assign data_o  = mem_q[rdPtr_q];
  assign flag_o  = flag_q[rdPtr_q];
  assign count_o = count_q;

endmodule

// File: rtl/exu_lsu.sv
// Load/store unit between the execute stage and a pipelined grant/rvalid
// bus. Requests issue combinationally, responses return in order and
// loads write back one cycle after their response.
// Build option: EXU_LSU_MISALIGN_EXC_EN reports misaligned half/word
// accesses on misaligned_o instead of silently aligning them.
module exu_lsu
  import tinyriscv_pkg::*;
#(
  parameter int OUTSTANDING = 2,
  parameter int RD_W        = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_signed_i,
  input  logic [31:0]     req_addr_i,
  input  logic [31:0]     req_wdata_i,
  input  logic [RD_W-1:0] req_rd_i,
  input  logic            flush_i,
  output logic            mem_req_o,
  input  logic            mem_gnt_i,
  output logic [31:0]     mem_addr_o,
  output logic            mem_we_o,
  output logic [3:0]      mem_be_o,
  output logic [31:0]     mem_wdata_o,
  input  logic            mem_rvalid_i,
  input  logic [31:0]     mem_rdata_i,
  output logic            wb_valid_o,
  output logic [RD_W-1:0] wb_waddr_o,
  output logic [31:0]     wb_wdata_o,
  output logic            busy_o,
  output logic            misaligned_o
);

  localparam int CNT_W  = $clog2(OUTSTANDING + 1);
  localparam int FIFO_W = LSU_ENTRY_W + RD_W;

  lsu_size_e         reqSize;
  logic [1:0]        issueOff;
  logic              misalignReq;
  logic              full;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  count;
  lsu_entry_t        pushEntry;
  lsu_entry_t        headEntry;
  logic [RD_W-1:0]   headRd;
  logic              headDiscard;
  logic [FIFO_W-1:0] pushData;
  logic [FIFO_W-1:0] headData;

  logic              wb_valid_q, wb_valid_d;
  logic [RD_W-1:0]   wb_waddr_q, wb_waddr_d;
  logic [31:0]       wb_wdata_q, wb_wdata_d;

  assign reqSize = lsu_size_e'(req_size_i);

  // Decide the lane offset actually issued and whether the access is misaligned.
  always_comb begin
    issueOff    = req_addr_i[1:0];
    misalignReq = 1'b0;
`ifdef EXU_LSU_MISALIGN_EXC_EN
    case (reqSize)
      LSU_SIZE_BYTE: misalignReq = 1'b0;
      LSU_SIZE_HALF: misalignReq = req_addr_i[0];
      default:       misalignReq = |req_addr_i[1:0];
    endcase
`else
    case (reqSize)
      LSU_SIZE_BYTE: issueOff = req_addr_i[1:0];
      LSU_SIZE_HALF: issueOff = {req_addr_i[1], 1'b0};
      default:       issueOff = 2'b00;
    endcase
`endif
  end

  // Byte enables follow the lane offset; store data is copied into every lane.
  always_comb begin
    mem_be_o    = 4'b1111;
    mem_wdata_o = req_wdata_i;
    case (reqSize)
      LSU_SIZE_BYTE: begin
        mem_be_o    = 4'b0001 << issueOff;
        mem_wdata_o = {4{req_wdata_i[7:0]}};
      end
      LSU_SIZE_HALF: begin
        mem_be_o    = 4'b0011 << issueOff;
        mem_wdata_o = {2{req_wdata_i[15:0]}};
      end
      default: begin
        mem_be_o    = 4'b1111;
        mem_wdata_o = req_wdata_i;
      end
    endcase
  end

  // A response arriving this cycle frees a slot, so a full queue can still accept.
  assign full        = (count == CNT_W'(OUTSTANDING)) & ~mem_rvalid_i;
  assign mem_req_o   = req_valid_i & ~flush_i & ~full & ~misalignReq;
  assign push        = mem_req_o & mem_gnt_i;
  assign req_ready_o = push | (req_valid_i & ~flush_i & misalignReq);
  assign pop         = mem_rvalid_i & (count != '0);
  assign mem_addr_o  = {req_addr_i[31:2], 2'b00};
  assign mem_we_o    = req_we_i;
  assign busy_o      = (count != '0);

  assign pushEntry = '{we: req_we_i, size: reqSize, sgn: req_signed_i, off: issueOff};
  assign pushData  = {pushEntry, req_rd_i};
  assign {headEntry, headRd} = headData;

  exu_lsu_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (pushData),
    .pop_i   (pop),
    .mark_i  (flush_i),
    .data_o  (headData),
    .flag_o  (headDiscard),
    .count_o (count)
  );

  // Build the writeback for the response being retired this cycle.
  always_comb begin
    wb_valid_d = pop & ~headEntry.we & ~headDiscard & ~flush_i;
    wb_waddr_d = headRd;
    wb_wdata_d = lsu_extend(mem_rdata_i, headEntry);
  end

  // Writeback register; address and data only change when a load retires.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_waddr_q <= '0;
      wb_wdata_q <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      if (wb_valid_d) begin
        wb_waddr_q <= wb_waddr_d;
        wb_wdata_q <= wb_wdata_d;
      end
    end
  end

  assign wb_valid_o = wb_valid_q;
  assign wb_waddr_o = wb_waddr_q;
  assign wb_wdata_o = wb_wdata_q;

`ifdef EXU_LSU_MISALIGN_EXC_EN
  logic misaligned_q;

  // One-cycle pulse for each rejected misaligned request.
  always_ff @(posedge clk) begin
    if (!rst_n) misaligned_q <= 1'b0;
    else        misaligned_q <= req_valid_i & ~flush_i & misalignReq;
  end

  assign misaligned_o = misaligned_q;
`else
  assign misaligned_o = 1'b0;
`endif

endmodule
